i2c_target_regfile: RTL and testbench



---
 rtl/hdmi_pkg.sv | 33 +++
 rtl/i2c_line_filter.sv | 60 ++++++
 rtl/i2c_target_regfile.sv | 265 ++++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : hdmi_pkg                                                    |
// | Purpose    : Shared types and constants for the HDMI transmitter         |
// |              configuration path: I2C target FSM state encoding, the      |
// |              ADV7513 main-map target address and the I2C ACK/NACK levels.|
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package hdmi_pkg;

    // I2C target protocol states
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_SUB      = 4'd3,
        ST_SUB_ACK  = 4'd4,
        ST_WDATA    = 4'd5,
        ST_WACK     = 4'd6,
        ST_RDATA    = 4'd7,
        ST_RACK     = 4'd8,
        ST_IGNORE   = 4'd9
    } i2c_state_e;

    // ADV7513 main register map, 7-bit form (8'h72 / 8'h73 on the wire)
    localparam logic [6:0] ADV7513_ADDR = 7'h39;

    // SDA level in the acknowledge slot
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : i2c_line_filter                                             |
// | Purpose    : Conditions one raw I2C pad level: 2-flop synchroniser,      |
// |              FILTER_LEN-sample glitch filter and one-cycle edge strobes. |
// | Ports      : clock50  - system clock                                     |
// |              reset_n  - asynchronous active-low reset                    |
// |              pad_in   - raw pad level                                    |
// |              level    - filtered level (resets to 1, idle bus)           |
// |              rise     - one-cycle strobe when level goes 0->1            |
// |              fall     - one-cycle strobe when level goes 1->0            |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clock50,
    input  logic reset_n,
    input  logic pad_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LIM = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // The synchroniser resets to 1 so that leaving reset on an idle bus
    // never looks like an edge.  A new level is accepted once it has been
    // seen on FILTER_LEN consecutive samples; the strobe is registered in
    // the same cycle as the level update so both change together.
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pad_in};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == LIM) begin
                level <= sync_q[1];
                cnt_q <= '0;
                rise  <= sync_q[1];
                fall  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : i2c_target_regfile                                          |
// | Purpose    : I2C target with a 256x8 register file mirroring the ADV7513 |
// |              main map.  Acknowledges writes and reads at DEV_ADDR,       |
// |              auto-increments the register pointer and reports every     |
// |              committed write byte on a local strobe.                     |
// | Ports      : clock50  - 50 MHz system clock                              |
// |              reset_n  - asynchronous active-low reset                    |
// |              scl_in   - raw SCL pad level                                |
// |              sda_in   - raw SDA pad level                                |
// |              sda_oe   - 1 = pull SDA low (open drain)                    |
// |              wr_valid - one-cycle pulse per committed write byte         |
// |              wr_addr  - register index of the committed byte             |
// |              wr_data  - value of the committed byte                      |
// |              rd_addr  - local read index                                 |
// |              rd_data  - registered regfile[rd_addr]                      |
// |              busy     - high between START and STOP                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module i2c_target_regfile
    import hdmi_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = ADV7513_ADDR,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clock50,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy
);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clock50 (clock50),
        .reset_n (reset_n),
        .pad_in  (scl_in),
        .level   (scl_f),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clock50 (clock50),
        .reset_n (reset_n),
        .pad_in  (sda_in),
        .level   (sda_f),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    // Both lines share the same filter latency, so their relative timing
    // is preserved and these conditions are exact.
    logic start_cond, stop_cond;
    assign start_cond = sda_fall & scl_f;
    assign stop_cond  = sda_rise & scl_f;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    i2c_state_e state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    // In the ACK states: 0 = waiting for the fall that ends bit 7,
    // 1 = ACK being driven.  In RDATA: 1 = all 8 bits have been clocked.
    logic       phase_q, phase_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_oe_d;
    logic       busy_d;
    logic       we;
    logic       load_rd;

    logic [7:0] regfile [256];

    // Byte completed by the bit sampled on the current scl_rise
    logic [7:0] rx_byte;
    assign rx_byte = {sr_q[6:0], sda_f};

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            phase_q  <= 1'b0;
            sr_q     <= 8'h00;
            ptr_q    <= 8'h00;
            rw_q     <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            phase_q  <= phase_d;
            sr_q     <= sr_d;
            ptr_q    <= ptr_d;
            rw_q     <= rw_d;
            sda_oe   <= sda_oe_d;
            busy     <= busy_d;
            wr_valid <= we;
            if (we) begin
                wr_addr <= ptr_q;
                wr_data <= rx_byte;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        phase_d  = phase_q;
        sr_d     = sr_q;
        ptr_d    = ptr_q;
        rw_d     = rw_q;
        sda_oe_d = sda_oe;
        busy_d   = busy;
        we       = 1'b0;
        load_rd  = 1'b0;

        if (start_cond) begin
            // Also covers repeated START; the pointer is deliberately kept
            state_d  = ST_ADDR;
            bitcnt_d = 3'd0;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_cond) begin
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        sr_d     = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_SUB) begin
                                ptr_d   = rx_byte;
                                state_d = ST_SUB_ACK;
                            end else begin
                                // Committed before the ACK slot
                                we      = 1'b1;
                                ptr_d   = ptr_q + 8'd1;
                                state_d = ST_WACK;
                            end
                        end
                    end
                end

                ST_ADDR_ACK, ST_SUB_ACK, ST_WACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = ~I2C_ACK;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            bitcnt_d = 3'd0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                // The fall ending the ACK also presents
                                // the first read bit
                                state_d = ST_RDATA;
                                load_rd = 1'b1;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_SUB;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (phase_q) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_RACK;
                        end else if (bitcnt_q == 3'd0) begin
                            // First fall after an ACKed read byte
                            load_rd = 1'b1;
                        end else begin
                            sda_oe_d = ~sr_q[3'd7 - bitcnt_q];
                        end
                    end
                end

                ST_RACK: begin
                    if (scl_rise) begin
                        bitcnt_d = 3'd0;
                        phase_d  = 1'b0;
                        if (sda_f == I2C_NACK) begin
                            state_d = ST_IGNORE;
                        end else begin
                            state_d = ST_RDATA;
                        end
                    end
                end

                default: begin
                    // IDLE and IGNORE only leave on START/STOP
                end
            endcase

            if (load_rd) begin
                sr_d     = regfile[ptr_q];
                ptr_d    = ptr_q + 8'd1;
                sda_oe_d = ~regfile[ptr_q][7];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file and local read port.  A same-cycle write to rd_addr
    // returns the old value; the new one is visible a cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) begin
                regfile[i] <= 8'h00;
            end
            rd_data <= 8'h00;
        end else begin
            if (we) begin
                regfile[ptr_q] <= rx_byte;
            end
            rd_data <= regfile[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_i2c_target_regfile                                       |
// | Purpose    : Self-checking bench for i2c_target_regfile: an I2C master   |
// |              model on an open-drain SDA, write-strobe logging, table-    |
// |              driven expected values and directed corner-case sequences.  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_i2c_target_regfile;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    logic       clock50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl     = 1'b1;
    logic       msda    = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_valid;
    logic       busy;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t wlog[$];
    vec_t burst_tbl[3];
    vec_t init_tbl[4];
    logic        ack;
    logic [7:0]  rbyte;
    logic [31:0] ga, gd, ev;

    assign sda_bus = msda & ~sda_oe;

    always #10 clock50 = ~clock50;

    i2c_target_regfile #(.DEV_ADDR(7'h39), .FILTER_LEN(3)) dut (
        .clock50  (clock50),
        .reset_n  (reset_n),
        .scl_in   (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always @(negedge clock50) begin
        if (reset_n && wr_valid) wlog.push_back('{wr_addr, wr_data});
    end

    initial begin
        repeat (60000) @(negedge clock50);
        $display("FAIL watchdog: run time 60000 cycles, required completion earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock50);
    endtask

    task automatic i2c_start();
        cyc(10); msda = 1'b1; cyc(10); scl = 1'b1; cyc(20);
        msda = 1'b0; cyc(20); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(10); msda = 1'b0; cyc(10); scl = 1'b1; cyc(20);
        msda = 1'b1; cyc(20);
    endtask

    // 8 data bits; optional 2-cycle glitch on SCL or SDA during a bit's high phase
    task automatic send_bits(input logic [7:0] b, input int g_scl, input int g_sda);
        for (int i = 7; i >= 0; i--) begin
            cyc(10); msda = b[i]; cyc(10); scl = 1'b1;
            if (i == g_scl) begin
                cyc(8); scl = 1'b0; cyc(2); scl = 1'b1; cyc(10);
            end else if (i == g_sda) begin
                cyc(8); msda = ~b[i]; cyc(2); msda = b[i]; cyc(10);
            end else begin
                cyc(20);
            end
            scl = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input int g_scl, input int g_sda,
                              output logic a);
        send_bits(b, g_scl, g_sda);
        cyc(10); msda = 1'b1; cyc(10); scl = 1'b1; cyc(10);
        a = sda_bus;
        cyc(10); scl = 1'b0;
    endtask

    task automatic read_byte(input logic ackbit, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            cyc(10); msda = 1'b1; cyc(10); scl = 1'b1; cyc(10);
            b[i] = sda_bus;
            cyc(10); scl = 1'b0;
        end
        cyc(10); msda = ackbit; cyc(10); scl = 1'b1; cyc(20); scl = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        rd_addr = a;
        cyc(2);
        chk(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic log_chk(input string tag, input int idx, input vec_t exp);
        if (idx < wlog.size()) begin
            ga = {24'd0, wlog[idx].addr};
            gd = {24'd0, wlog[idx].data};
        end else begin
            ga = 32'hFFFF_FFFF;
            gd = 32'hFFFF_FFFF;
        end
        chk($sformatf("%s_wr_addr[%0d]", tag, idx), ga, {24'd0, exp.addr});
        chk($sformatf("%s_wr_data[%0d]", tag, idx), gd, {24'd0, exp.data});
    endtask

    initial begin
        burst_tbl[0] = '{8'hFE, 8'h11};
        burst_tbl[1] = '{8'hFF, 8'h22};
        burst_tbl[2] = '{8'h00, 8'h33};
        init_tbl[0]  = '{8'h41, 8'h10};
        init_tbl[1]  = '{8'h98, 8'h03};
        init_tbl[2]  = '{8'h9A, 8'hE0};
        init_tbl[3]  = '{8'hD6, 8'hC0};

        // ---------------- reset state ----------------
        reset_n = 1'b0;
        cyc(5);
        chk("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_wr_addr",  {24'd0, wr_addr},  32'd0);
        chk("rst_wr_data",  {24'd0, wr_data},  32'd0);
        chk("rst_rd_data",  {24'd0, rd_data},  32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        reset_n = 1'b1;
        cyc(20);

        // ---------------- write burst with pointer wrap ----------------
        wlog.delete();
        i2c_start();
        cyc(2);
        chk("wb_busy_after_start", {31'd0, busy}, 32'd1);
        write_byte(8'h72, -1, -1, ack); chk("wb_ack_addr", {31'd0, ack}, 32'd0);
        write_byte(8'hFE, -1, -1, ack); chk("wb_ack_sub",  {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            write_byte(burst_tbl[i].data, -1, -1, ack);
            chk($sformatf("wb_ack_data[%0d]", i), {31'd0, ack}, 32'd0);
        end
        i2c_stop();
        chk("wb_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("wb_wr_count", wlog.size(), 32'd3);
        for (int i = 0; i < 3; i++) log_chk("wb", i, burst_tbl[i]);
        for (int i = 0; i < 3; i++)
            rd_chk($sformatf("wb_rd[%0h]", burst_tbl[i].addr), burst_tbl[i].addr, burst_tbl[i].data);

        // ---------------- read burst via repeated START ----------------
        wlog.delete();
        i2c_start();
        write_byte(8'h72, -1, -1, ack); chk("rb_ack_addr_w", {31'd0, ack}, 32'd0);
        write_byte(8'hFE, -1, -1, ack); chk("rb_ack_sub",    {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'h73, -1, -1, ack); chk("rb_ack_addr_r", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            read_byte((i == 2) ? 1'b1 : 1'b0, rbyte);
            chk($sformatf("rb_data[%0d]", i), {24'd0, rbyte}, {24'd0, burst_tbl[i].data});
        end
        cyc(5);
        chk("rb_sda_released", {31'd0, sda_oe}, 32'd0);
        write_byte(8'h00, -1, -1, ack);
        chk("rb_ignore_no_ack", {31'd0, ack}, 32'd1);
        chk("rb_busy_before_stop", {31'd0, busy}, 32'd1);
        i2c_stop();
        chk("rb_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("rb_no_wr_valid", wlog.size(), 32'd0);

        // ---------------- wrong address ----------------
        wlog.delete();
        i2c_start();
        write_byte(8'h70, -1, -1, ack); chk("wa_no_ack",      {31'd0, ack}, 32'd1);
        write_byte(8'h55, -1, -1, ack); chk("wa_no_ack_data", {31'd0, ack}, 32'd1);
        chk("wa_busy", {31'd0, busy}, 32'd1);
        i2c_stop();
        chk("wa_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("wa_no_wr_valid", wlog.size(), 32'd0);

        // ---------------- glitch rejection on SCL and SDA ----------------
        wlog.delete();
        i2c_start();
        write_byte(8'h72, -1, -1, ack); chk("gl_ack_addr", {31'd0, ack}, 32'd0);
        write_byte(8'h10, -1, -1, ack); chk("gl_ack_sub",  {31'd0, ack}, 32'd0);
        write_byte(8'hA5,  4,  7, ack); chk("gl_ack_data", {31'd0, ack}, 32'd0);
        i2c_stop();
        chk("gl_wr_count", wlog.size(), 32'd1);
        log_chk("gl", 0, '{8'h10, 8'hA5});
        rd_chk("gl_rd_10", 8'h10, 8'hA5);

        // ---------------- reset while ACK is driven ----------------
        i2c_start();
        send_bits(8'h72, -1, -1);
        cyc(10);
        chk("rm_sda_oe_in_ack", {31'd0, sda_oe}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rm_sda_oe_async", {31'd0, sda_oe}, 32'd0);
        chk("rm_busy", {31'd0, busy}, 32'd0);
        cyc(3);
        msda = 1'b1; scl = 1'b1;
        cyc(10);
        reset_n = 1'b1;
        cyc(20);
        rd_chk("rm_rd_fe", 8'hFE, 8'h00);
        rd_chk("rm_rd_10", 8'h10, 8'h00);

        // ---------------- ADV7513 init replay ----------------
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            i2c_start();
            write_byte(8'h72, -1, -1, ack);
            chk($sformatf("ini_ack_addr[%0d]", i), {31'd0, ack}, 32'd0);
            write_byte(init_tbl[i].addr, -1, -1, ack);
            chk($sformatf("ini_ack_sub[%0d]", i), {31'd0, ack}, 32'd0);
            write_byte(init_tbl[i].data, -1, -1, ack);
            chk($sformatf("ini_ack_data[%0d]", i), {31'd0, ack}, 32'd0);
            i2c_stop();
        end
        chk("ini_wr_count", wlog.size(), 32'd4);
        for (int i = 0; i < 4; i++) log_chk("ini", i, init_tbl[i]);
        for (int a = 0; a < 256; a++) begin
            ev = 32'd0;
            for (int k = 0; k < 4; k++)
                if (init_tbl[k].addr == 8'(a)) ev = {24'd0, init_tbl[k].data};
            rd_chk($sformatf("ini_reg[%02h]", a), 8'(a), ev[7:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
